// File: rtl/at5351_top_if.sv
// SPI bus shared between the AT5351 front end and the UFM flash.
//   spi_clk  : serial clock from the master (idle low)
//   spi_mosi : master-to-slave data, LSB first
//   spi_cs   : slave select, active-low
//   spi_miso : slave-to-master data
//   ufm_sn   : UFM flash select, active-low; low means the UFM owns the bus
interface at5351_top_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_cs;
    logic spi_miso;
    logic ufm_sn;

    modport master (output spi_clk, spi_mosi, spi_cs, ufm_sn, input spi_miso);
    modport slave  (input spi_clk, spi_mosi, spi_cs, ufm_sn, output spi_miso);
endinterface

// File: rtl/at5351_top.sv
// AT5351 capacitance front end.
// The block distributes and divides the 12 MHz clock and generates the
// measurement gate. It counts edges on the P and M comparator channels,
// debounces the reference-oscillator comparator and holds the AVK channel-1
// SR state. An SPI slave returns the latched 24-bit result for the selected
// channel.
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   clk_12mhz / clk_div_6    : buffered clock, clk/DIV at 50% duty
//   clk_5ms / clk_not_5ms    : measurement gate and its inverse
//   comparator -> antibounce : debounced comparator; reference = ~antibounce
//   pos/neg_comparator       : channel P/M pulse inputs
//   pos/neg_comparator1      : AVK set/clear pulses -> ref_avk
//   counter                  : live P accumulator
//   count                    : latched result of the channel chosen by cnt_choise
//   spi                      : SPI slave bus (slave modport)
module at5351_top #(
    parameter int DIV         = 6,
    parameter int GATE_CYCLES = 60000,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clk_12mhz,
    output logic             clk_div_6,
    output logic             clk_5ms,
    output logic             clk_not_5ms,
    input  logic             comparator,
    output logic             antibounce,
    output logic             reference,
    input  logic             pos_comparator,
    input  logic             neg_comparator,
    input  logic             pos_comparator1,
    input  logic             neg_comparator1,
    output logic             ref_avk,
    output logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] count,
    output logic             cnt_choise,
    at5351_top_if.slave      spi
);
    localparam int DIV_HALF = DIV / 2;
    localparam int DIV_W    = $clog2(DIV_HALF + 1);
    localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);

    // Synchroniser bit positions
    localparam int I_P = 0, I_N = 1, I_P1 = 2, I_N1 = 3, I_SCK = 4, I_CS = 5;
    localparam int I_CMP = 6, I_MOSI = 7, I_UFM = 8;

    assign clk_12mhz   = clk;
    assign clk_not_5ms = ~clk_5ms;
    assign reference   = ~antibounce;

    // ---------------- clock divider ----------------
    logic [DIV_W-1:0] div_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            clk_div_6 <= 1'b0;
        end else if (div_cnt == DIV_W'(DIV_HALF - 1)) begin
            div_cnt   <= '0;
            clk_div_6 <= ~clk_div_6;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- measurement gate ----------------
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_wrap, gate_fall;
    assign gate_wrap = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign gate_fall = gate_wrap & clk_5ms;

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
            clk_5ms  <= 1'b0;
        end else if (gate_wrap) begin
            gate_cnt <= '0;
            clk_5ms  <= ~clk_5ms;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // ---------------- input synchronisers ----------------
    logic [8:0] async_in, sync1, s;
    logic [5:0] prev;   // delayed copy of the edge-detected inputs
    assign async_in = {spi.ufm_sn, spi.spi_mosi, comparator, spi.spi_cs, spi.spi_clk,
                       neg_comparator1, pos_comparator1, neg_comparator, pos_comparator};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
            prev  <= '0;
        end else begin
            sync1 <= async_in;
            s     <= sync1;
            prev  <= s[5:0];
        end
    end

    logic p_rise, n_rise, p1_rise, n1_rise, sck_fall, cs_fall, cs_rise;
    assign p_rise   = s[I_P]   & ~prev[I_P];
    assign n_rise   = s[I_N]   & ~prev[I_N];
    assign p1_rise  = s[I_P1]  & ~prev[I_P1];
    assign n1_rise  = s[I_N1]  & ~prev[I_N1];
    assign sck_fall = ~s[I_SCK] & prev[I_SCK];
    assign cs_fall  = ~s[I_CS]  & prev[I_CS];
    assign cs_rise  = s[I_CS]  & ~prev[I_CS];

    // ---------------- channel P/M accumulators ----------------
    logic [CNT_W-1:0] acc_p, acc_m, count_p, count_m;
    assign counter = acc_p;
    assign count   = cnt_choise ? count_p : count_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p   <= '0;
            acc_m   <= '0;
            count_p <= '0;
            count_m <= '0;
        end else if (gate_fall) begin
            // latch and clear together; an edge landing here is dropped
            count_p <= acc_p;
            count_m <= acc_m;
            acc_p   <= '0;
            acc_m   <= '0;
        end else if (clk_5ms) begin
            if (p_rise && acc_p != '1) acc_p <= acc_p + 1'b1;
            if (n_rise && acc_m != '1) acc_m <= acc_m + 1'b1;
        end
    end

    // ---------------- comparator debounce ----------------
    logic [DEB_W-1:0] deb_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            antibounce <= 1'b0;
            deb_cnt    <= '0;
        end else if (s[I_CMP] == antibounce) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            antibounce <= s[I_CMP];
            deb_cnt    <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // ---------------- AVK channel 1 SR (clear dominates) ----------------
    always_ff @(posedge clk) begin
        if (rst)          ref_avk <= 1'b0;
        else if (n1_rise) ref_avk <= 1'b0;
        else if (p1_rise) ref_avk <= 1'b1;
    end

    // ---------------- SPI slave ----------------
    // snap shifts right on every clock fall, so its LSB is always the bit on
    // the wire and bits past CNT_W come out as zero.
    logic             xfer;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] snap;
    logic [6:0]       cmd;        // last seven MOSI bits
    logic [7:0]       cmd_next;
    assign cmd_next     = {s[I_MOSI], cmd};
    assign spi.spi_miso = xfer & s[I_UFM] & ~s[I_CS] & snap[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer       <= 1'b0;
            bit_cnt    <= '0;
            snap       <= '0;
            cmd        <= '0;
            cnt_choise <= 1'b0;
        end else if (!s[I_UFM] || cs_rise) begin
            xfer <= 1'b0;
        end else if (cs_fall) begin
            xfer    <= 1'b1;
            bit_cnt <= '0;
            snap    <= count;
        end else if (xfer && sck_fall) begin
            cmd  <= cmd_next[7:1];
            snap <= snap >> 1;
            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
            // eighth bit completes the command byte
            if (bit_cnt == 4'd7 && cmd_next[7:4] == 4'hF) cnt_choise <= cmd_next[0];
        end
    end
endmodule

// File: tb/tb_at5351_top.sv
module tb_at5351_top;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_12mhz, clk_div_6, clk_5ms, clk_not_5ms;
    logic          comparator = 1'b0, antibounce, reference;
    logic          pos_comparator = 1'b0, neg_comparator = 1'b0;
    logic          pos_comparator1 = 1'b0, neg_comparator1 = 1'b0, ref_avk;
    logic [CW-1:0] counter, count;
    logic          cnt_choise;

    at5351_top_if spi();

    at5351_top #(.DIV(6), .GATE_CYCLES(100), .DEB_CYCLES(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .clk_12mhz(clk_12mhz), .clk_div_6(clk_div_6),
        .clk_5ms(clk_5ms), .clk_not_5ms(clk_not_5ms), .comparator(comparator),
        .antibounce(antibounce), .reference(reference),
        .pos_comparator(pos_comparator), .neg_comparator(neg_comparator),
        .pos_comparator1(pos_comparator1), .neg_comparator1(neg_comparator1),
        .ref_avk(ref_avk), .counter(counter), .count(count),
        .cnt_choise(cnt_choise), .spi(spi)
    );

    always #5 clk = ~clk;

    int   checks = 0, failures = 0;
    logic exp_q[$];
    int   np = 37, nm = 5;   // pulses per gate on P / M
    logic cc_m = 1'b0;       // model of cnt_choise
    logic gen_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_gate(input logic lvl, input string tag);
        int n = 0;
        while (clk_5ms !== lvl && n < 400) begin tick(1); n++; end
        chk(tag, clk_5ms, lvl);
    endtask

    // Pulse generator: every gate-high phase gets np P pulses and nm M pulses.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (clk_5ms && !gen_prev) begin
                for (int k = 0; k < ((np > nm) ? np : nm); k++) begin
                    pos_comparator = (k < np);
                    neg_comparator = (k < nm);
                    @(posedge clk); #1;
                    pos_comparator = 1'b0;
                    neg_comparator = 1'b0;
                    @(posedge clk); #1;
                end
            end
            gen_prev = clk_5ms;
        end
    end

    // SPI master, mode 1, LSB first. Expected MISO bits are queued at cs fall
    // from the model and popped as each bit is sampled.
    task automatic spi_xfer(input logic [31:0] mo, input int nbits, input logic own,
                            input logic keep_cs);
        logic [CW-1:0] e;
        logic          eb;
        spi.ufm_sn = own;
        tick(4);
        spi.spi_cs = 1'b0;
        e = own ? (cc_m ? CW'(np) : CW'(nm)) : '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < CW) exp_q.push_back(e[i]);
            else        exp_q.push_back(1'b0);
        end
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            spi.spi_mosi = mo[i];
            spi.spi_clk  = 1'b1;
            tick(4);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            chk("miso", spi.spi_miso, eb);
            spi.spi_clk = 1'b0;
            tick(4);
        end
        if (own && nbits >= 8 && mo[7:4] == 4'hF) cc_m = mo[0];
        if (!keep_cs) begin
            spi.spi_cs = 1'b1;
            tick(6);
            spi.ufm_sn = 1'b1;
            tick(4);
        end
    endtask

    initial begin
        logic v;
        int   n;
        spi.spi_clk = 1'b0; spi.spi_mosi = 1'b0; spi.spi_cs = 1'b1; spi.ufm_sn = 1'b1;

        // 1: reset state, divider, gate
        tick(10);
        chk("rst_clk_5ms", clk_5ms, 0);
        chk("rst_clk_not_5ms", clk_not_5ms, 1);
        chk("rst_clk_div_6", clk_div_6, 0);
        chk("rst_antibounce", antibounce, 0);
        chk("rst_reference", reference, 1);
        chk("rst_ref_avk", ref_avk, 0);
        chk("rst_counter", counter, 0);
        chk("rst_count", count, 0);
        chk("rst_cnt_choise", cnt_choise, 0);
        chk("rst_miso", spi.spi_miso, 0);
        chk("clk_12mhz", clk_12mhz, clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            v = clk_div_6;
            chk("clk_div_6", v, ((i + 1) / 3) % 2);
        end
        n = 12;
        while (!clk_5ms && n < 300) begin tick(1); n++; end
        chk("gate_first_rise", n, 100);
        chk("clk_not_5ms", clk_not_5ms, 0);

        // 2: P/M counting across one gate
        tick(90);
        chk("counter_in_gate", counter, 37);
        wait_gate(1'b0, "gate_fall");
        chk("count_m", count, 5);
        chk("acc_cleared", counter, 0);

        // 3: select P, then read it back with bits past 24
        spi_xfer(32'hF9, 24, 1'b1, 1'b0);
        chk("sel_p", cnt_choise, 1);
        chk("count_p", count, 37);
        spi_xfer(32'h0, 32, 1'b1, 1'b0);
        spi_xfer(32'hF8, 6, 1'b1, 1'b0);   // aborted mid-byte
        chk("abort_no_cmd", cnt_choise, 1);

        // 4: UFM owns the bus
        spi_xfer(32'hF8, 24, 1'b0, 1'b0);
        chk("ufm_hold", cnt_choise, 1);

        // AVK SR
        pos_comparator1 = 1'b1; tick(1); pos_comparator1 = 1'b0; tick(4);
        chk("avk_set", ref_avk, 1);
        neg_comparator1 = 1'b1; tick(1); neg_comparator1 = 1'b0; tick(4);
        chk("avk_clr", ref_avk, 0);
        pos_comparator1 = 1'b1; tick(1); pos_comparator1 = 1'b0; tick(4);
        pos_comparator1 = 1'b1; neg_comparator1 = 1'b1; tick(1);
        pos_comparator1 = 1'b0; neg_comparator1 = 1'b0; tick(4);
        chk("avk_both", ref_avk, 0);

        // 5: debounce
        comparator = 1'b1; tick(2); comparator = 1'b0; tick(10);
        chk("glitch_ab", antibounce, 0);
        chk("glitch_ref", reference, 1);
        comparator = 1'b1; tick(6);
        chk("held_ab", antibounce, 1);
        chk("held_ref", reference, 0);

        // 6: reset mid-transfer
        spi_xfer(32'h0, 12, 1'b1, 1'b1);
        np = 4; nm = 9;
        rst = 1'b1; tick(3);
        chk("midrst_choise", cnt_choise, 0);
        chk("midrst_miso", spi.spi_miso, 0);
        rst = 1'b0; cc_m = 1'b0;
        tick(4);
        spi.spi_clk = 1'b1; tick(4);
        chk("stale_miso", spi.spi_miso, 0);
        spi.spi_clk = 1'b0; tick(4);
        chk("stale_choise", cnt_choise, 0);
        spi.spi_cs = 1'b1; tick(6);
        wait_gate(1'b1, "gate_rise2");
        wait_gate(1'b0, "gate_fall2");
        chk("count_m2", count, 9);
        spi_xfer(32'h0, 24, 1'b1, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
